// File: rtl/s38584_match_arm_seq.sv
// Multi-channel gated arm/compare sequencer: arm on qualified request, fire on field match, hold, pulse done.
// Optional build macro S38584_ARM_TIMEOUT_EN adds an ARMED-state timeout (TO_CYC, timeout output).
module s38584_match_arm_seq #(
  parameter int unsigned     NCH      = 4,
  parameter int unsigned     FW       = 2,
  parameter int unsigned     QW       = 7,
  parameter logic [QW-1:0]   QPOL     = QW'(7'b0000011),
  parameter int unsigned     HOLD_CYC = 3
`ifdef S38584_ARM_TIMEOUT_EN
  ,
  parameter int unsigned     TO_CYC   = 16
`endif
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              en,
  input  logic [QW-1:0]     qual,
  input  logic [NCH-1:0]    arm,
  input  logic [NCH-1:0]    clr,
  input  logic [NCH*FW-1:0] fa,
  input  logic [NCH*FW-1:0] fb,
  output logic [NCH-1:0]    armed,
  output logic [NCH-1:0]    hold,
  output logic [NCH-1:0]    done,
`ifdef S38584_ARM_TIMEOUT_EN
  output logic [NCH-1:0]    timeout,
`endif
  output logic              any_hold
);

  localparam int unsigned CW = 8;

  generate
    if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_hold
      $error("HOLD_CYC must be in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t         state_q [NCH];
  state_t         state_d [NCH];
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [NCH-1:0] done_d;
  logic [NCH-1:0] armed_d;
  logic [NCH-1:0] hold_d;
  logic           q_ok;

`ifdef S38584_ARM_TIMEOUT_EN
  localparam int unsigned TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  logic [TW-1:0]  to_q [NCH];
  logic [TW-1:0]  to_d [NCH];
  logic [NCH-1:0] timeout_d;
`endif

  // Per-channel next-state, hold counter and pulse generation
  always_comb begin
    q_ok    = &(~(qual ^ QPOL));
    done_d  = '0;
    armed_d = '0;
    hold_d  = '0;
`ifdef S38584_ARM_TIMEOUT_EN
    timeout_d = '0;
`endif
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef S38584_ARM_TIMEOUT_EN
      to_d[i]    = to_q[i];
`endif
      if (en) begin
        if (clr[i]) begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end else begin
          case (state_q[i])
            ST_IDLE: begin
              if (arm[i] && q_ok) begin
                state_d[i] = ST_ARMED;
`ifdef S38584_ARM_TIMEOUT_EN
                to_d[i]    = '0;
`endif
              end
            end
            ST_ARMED: begin
              if (q_ok && (fa[i*FW +: FW] == fb[i*FW +: FW])) begin
                state_d[i] = ST_HOLD;
                cnt_d[i]   = CW'(HOLD_CYC - 1);
              end else if (!q_ok) begin
                state_d[i] = ST_IDLE;
`ifdef S38584_ARM_TIMEOUT_EN
              end else if (to_q[i] == TW'(TO_CYC - 1)) begin
                state_d[i]   = ST_IDLE;
                timeout_d[i] = 1'b1;
              end else begin
                to_d[i] = to_q[i] + TW'(1);
`endif
              end
            end
            ST_HOLD: begin
              if (cnt_q[i] == '0) begin
                state_d[i] = ST_IDLE;
                done_d[i]  = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] - CW'(1);
              end
            end
            default: state_d[i] = ST_IDLE;
          endcase
        end
      end
      armed_d[i] = (state_d[i] == ST_ARMED);
      hold_d[i]  = (state_d[i] == ST_HOLD);
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
`ifdef S38584_ARM_TIMEOUT_EN
        to_q[i]    <= '0;
`endif
      end
      armed    <= '0;
      hold     <= '0;
      done     <= '0;
      any_hold <= 1'b0;
`ifdef S38584_ARM_TIMEOUT_EN
      timeout  <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef S38584_ARM_TIMEOUT_EN
        to_q[i]    <= to_d[i];
`endif
      end
      armed    <= armed_d;
      hold     <= hold_d;
      done     <= done_d;
      any_hold <= |hold_d;
`ifdef S38584_ARM_TIMEOUT_EN
      timeout  <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_s38584_match_arm_seq.sv
// Randomized bench for s38584_match_arm_seq against a cycle-level behavioural model.
module tb_s38584_match_arm_seq;

  localparam int unsigned   NCH      = 4;
  localparam int unsigned   FW       = 2;
  localparam int unsigned   QW       = 7;
  localparam int unsigned   HOLD_CYC = 3;
  localparam logic [QW-1:0] QPOL     = 7'b0000011;
`ifdef S38584_ARM_TIMEOUT_EN
  localparam int unsigned   TO_CYC   = 16;
`endif

  logic              ck = 1'b0;
  logic              rst;
  logic              en;
  logic [QW-1:0]     qual;
  logic [NCH-1:0]    arm;
  logic [NCH-1:0]    clr;
  logic [NCH*FW-1:0] fa;
  logic [NCH*FW-1:0] fb;
  logic [NCH-1:0]    armed;
  logic [NCH-1:0]    hold;
  logic [NCH-1:0]    done;
  logic              any_hold;
`ifdef S38584_ARM_TIMEOUT_EN
  logic [NCH-1:0]    timeout;
`endif

  s38584_match_arm_seq #(
    .NCH(NCH), .FW(FW), .QW(QW), .QPOL(QPOL), .HOLD_CYC(HOLD_CYC)
`ifdef S38584_ARM_TIMEOUT_EN
    , .TO_CYC(TO_CYC)
`endif
  ) dut (
    .ck(ck), .rst(rst), .en(en), .qual(qual), .arm(arm), .clr(clr),
    .fa(fa), .fb(fb), .armed(armed), .hold(hold), .done(done),
`ifdef S38584_ARM_TIMEOUT_EN
    .timeout(timeout),
`endif
    .any_hold(any_hold)
  );

  always #5 ck = ~ck;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Model: mode 0 idle, 1 armed, 2 holding; hold_left counts remaining HOLD cycles.
  int             mode      [NCH];
  int             hold_left [NCH];
  int             armed_cyc [NCH];
  logic [NCH-1:0] e_done;
  logic [NCH-1:0] e_to;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      mode[i] = 0; hold_left[i] = 0; armed_cyc[i] = 0;
    end
    e_done = '0;
    e_to   = '0;
  endfunction

  function automatic void model_step();
    bit ok;
    ok     = (qual == QPOL);
    e_done = '0;
    e_to   = '0;
    if (!en) return;
    for (int i = 0; i < NCH; i++) begin
      bit m;
      m = (fa[i*FW +: FW] == fb[i*FW +: FW]);
      if (clr[i]) begin
        mode[i] = 0; hold_left[i] = 0;
      end else if (mode[i] == 0) begin
        if (arm[i] && ok) begin mode[i] = 1; armed_cyc[i] = 0; end
      end else if (mode[i] == 1) begin
        armed_cyc[i]++;
        if (ok && m) begin
          mode[i] = 2; hold_left[i] = HOLD_CYC;
        end else if (!ok) begin
          mode[i] = 0;
`ifdef S38584_ARM_TIMEOUT_EN
        end else if (armed_cyc[i] == TO_CYC) begin
          mode[i] = 0; e_to[i] = 1'b1;
`endif
        end
      end else begin
        hold_left[i]--;
        if (hold_left[i] == 0) begin mode[i] = 0; e_done[i] = 1'b1; end
      end
    end
  endfunction

  task automatic check_all();
    logic [NCH-1:0] ea, eh;
    for (int i = 0; i < NCH; i++) begin
      ea[i] = (mode[i] == 1);
      eh[i] = (mode[i] == 2);
    end
    check("armed", 32'(armed), 32'(ea));
    check("hold", 32'(hold), 32'(eh));
    check("done", 32'(done), 32'(e_done));
    check("any_hold", 32'(any_hold), 32'(|eh));
`ifdef S38584_ARM_TIMEOUT_EN
    check("timeout", 32'(timeout), 32'(e_to));
`endif
  endtask

  task automatic cycle();
    @(posedge ck);
    model_step();
    @(negedge ck);
    check_all();
  endtask

  task automatic set_idle_inputs();
    en = 1'b1; qual = '0; arm = '0; clr = '0; fa = '0; fb = '0;
  endtask

  initial begin
    bit quiet;
    rst = 1'b1;
    set_idle_inputs();
    repeat (2) @(posedge ck);
    @(negedge ck);
    rst = 1'b0;
    model_reset();
    check_all();
    cycle();

    // Arm ch0, match, hold, then freeze mid-hold and ignore clr while frozen
    qual = QPOL; arm = 4'b0001; fa = 8'h01; fb = 8'h00;
    cycle();
    arm = '0; fa[1:0] = 2'b10; fb[1:0] = 2'b10;
    cycle();
    cycle();
    en = 1'b0; clr = 4'b0001;
    repeat (5) cycle();
    en = 1'b1; clr = '0;
    repeat (4) cycle();

    // Arm all, match ch0/ch2, then abort ch2
    arm = 4'b1111; fa = 8'h00; fb = 8'hFF;
    cycle();
    arm = '0; fa = 8'h00; fb = 8'b11_00_11_00;
    cycle();
    clr = 4'b0100;
    cycle();
    clr = '0;
    cycle();
    // Async reset mid-cycle while holding
    #2 rst = 1'b1;
    #1 check("async_rst_hold", 32'(hold), 32'h0);
    check("async_rst_any", 32'(any_hold), 32'h0);
    model_reset();
    #1 rst = 1'b0;
    cycle();

    // Randomized phase; quiet windows keep qualifier good and fields mismatched
    for (int c = 0; c < 3000; c++) begin
      quiet = ((c / 64) % 4 == 3);
      en    = ($urandom_range(0, 9) != 0);
      qual  = ($urandom_range(0, 9) < (quiet ? 10 : 8)) ? QPOL
              : QPOL ^ (QW'(1) << $urandom_range(0, QW - 1));
      arm   = NCH'($urandom);
      for (int i = 0; i < NCH; i++) begin
        clr[i] = ($urandom_range(0, 29) == 0);
        fa[i*FW +: FW] = FW'($urandom);
        if (quiet && $urandom_range(0, 39) != 0) fb[i*FW +: FW] = ~fa[i*FW +: FW];
        else fb[i*FW +: FW] = FW'($urandom);
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 check("async_rst_armed", 32'(armed), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        model_reset();
        #1 rst = 1'b0;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
